// File: rtl/sim_harness_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sim_harness_pkg
// Purpose  : Shared types and constants for the simulation run controller.
//            state_e - controller FSM states
//            fail_e  - end-of-test failure classification
// Revision : 1.0 - initial release
// ============================================================================
package sim_harness_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FAIL_NONE    = 2'b00,
    FAIL_EXIT    = 2'b01,
    FAIL_TIMEOUT = 2'b10,
    FAIL_HANG    = 2'b11
  } fail_e;

  localparam logic [31:0] c_TOHOST_ADDR_DEFAULT = 32'h0000_1000;

endpackage
`default_nettype wire

// File: rtl/sim_harness_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sim_harness_ctrl_if
// Purpose  : Bundle of control, snoop and status signals between the run
//            controller and its environment (testbench / SoC wrapper).
//   start, retire_valid, mem_we, mem_addr, mem_wdata : into the controller
//   core_rst, running, done, pass, fail_code, exit_code,
//   cycle_count, retire_count                        : out of the controller
//   modport slave  - the controller side
//   modport master - the environment side
// Revision : 1.0 - initial release
// ============================================================================
interface sim_harness_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);

  logic             start;
  logic             retire_valid;
  logic             mem_we;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_wdata;

  logic             core_rst;
  logic             running;
  logic             done;
  logic             pass;
  logic [1:0]       fail_code;
  logic [XLEN-1:0]  exit_code;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] retire_count;

  modport slave (
    input  start, retire_valid, mem_we, mem_addr, mem_wdata,
    output core_rst, running, done, pass, fail_code, exit_code,
           cycle_count, retire_count
  );

  modport master (
    output start, retire_valid, mem_we, mem_addr, mem_wdata,
    input  core_rst, running, done, pass, fail_code, exit_code,
           cycle_count, retire_count
  );

endinterface
`default_nettype wire

// File: rtl/sim_harness_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : W-bit up-counter that sticks at all-ones instead of wrapping.
//   clk, rst : clock, asynchronous active-high reset (clears q)
//   clr      : synchronous clear, has priority over en
//   en       : count enable
//   q        : counter value
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         clr,
  input  wire logic         en,
  output logic      [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en && (r_q != {W{1'b1}})) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/sim_harness_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sim_harness_ctrl
// Purpose  : Run controller for processor simulation / FPGA bring-up.
//            Holds the core in reset for RST_CYCLES after start, runs it,
//            and ends the test on a tohost store, a retire stall (hang) or
//            a cycle-budget timeout. Reports pass/fail, exit code and
//            cycle / retired-instruction counts.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sim_harness_ctrl_if.slave (start, retire/memory snoop in;
//              core_rst, running, done, pass, fail_code, exit_code,
//              cycle_count, retire_count out)
// Revision : 1.0 - initial release
// ============================================================================
module sim_harness_ctrl
  import sim_harness_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              CNT_W       = 32,
  parameter int              RST_CYCLES  = 4,
  parameter int              MAX_CYCLES  = 1024,
  parameter int              STALL_LIMIT = 64,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(c_TOHOST_ADDR_DEFAULT)
) (
  input wire logic           clk,
  input wire logic           rst,
  sim_harness_ctrl_if.slave  bus
);

  localparam int HOLD_W  = $clog2(RST_CYCLES + 1);
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;

  logic              r_core_rst;
  logic              r_running;
  logic              r_done;
  logic              r_pass;
  fail_e             r_fail_code;
  logic [XLEN-1:0]   r_exit_code;

  logic              w_core_rst_nxt;
  logic              w_running_nxt;
  logic              w_done_nxt;
  logic              w_pass_nxt;
  fail_e             w_fail_nxt;
  logic [XLEN-1:0]   w_exit_nxt;

  logic [CNT_W-1:0]   w_cycle_q;
  logic [CNT_W-1:0]   w_retire_q;
  logic [STALL_W-1:0] w_stall_q;

  logic w_start_acc;
  logic w_in_run;
  logic w_tohost;
  logic w_hang;
  logic w_timeout;
  logic w_end;

  // start only matters when the controller is parked.
  assign w_start_acc = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_in_run    = (r_state == RUN);

  // End conditions look at the counter values this cycle will produce, so the
  // terminating cycle itself is included in the count that triggers it.
  assign w_tohost  = w_in_run && bus.mem_we && (bus.mem_addr == TOHOST_ADDR);
  assign w_hang    = w_in_run && !bus.retire_valid &&
                     (w_stall_q == STALL_W'(STALL_LIMIT - 1));
  assign w_timeout = w_in_run && (w_cycle_q == CNT_W'(MAX_CYCLES - 1));
  assign w_end     = w_tohost || w_hang || w_timeout;

  // --------------------------------------------------------------------------
  // Counters
  // --------------------------------------------------------------------------
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (w_start_acc),
    .en  (w_in_run),
    .q   (w_cycle_q)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk (clk),
    .rst (rst),
    .clr (w_start_acc),
    .en  (w_in_run && bus.retire_valid),
    .q   (w_retire_q)
  );

  sat_counter #(.W(STALL_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (w_start_acc || (w_in_run && bus.retire_valid)),
    .en  (w_in_run && !bus.retire_valid),
    .q   (w_stall_q)
  );

  // --------------------------------------------------------------------------
  // HOLD down-counter: loaded on start so HOLD lasts RST_CYCLES cycles
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= '0;
    end else if (w_start_acc) begin
      r_hold_cnt <= HOLD_W'(RST_CYCLES - 1);
    end else if ((r_state == HOLD) && (r_hold_cnt != '0)) begin
      r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start)          w_state_nxt = HOLD;
      HOLD:    if (r_hold_cnt == '0)   w_state_nxt = RUN;
      RUN:     if (w_end)              w_state_nxt = DONE;
      DONE:    if (bus.start)          w_state_nxt = HOLD;
      default:                         w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // --------------------------------------------------------------------------
  always_comb begin
    w_core_rst_nxt = (w_state_nxt != RUN);
    w_running_nxt  = (w_state_nxt == RUN);
    w_done_nxt     = r_done;
    w_pass_nxt     = r_pass;
    w_fail_nxt     = r_fail_code;
    w_exit_nxt     = r_exit_code;

    if (w_start_acc) begin
      w_done_nxt = 1'b0;
      w_pass_nxt = 1'b0;
      w_fail_nxt = FAIL_NONE;
      w_exit_nxt = '0;
    end else if (w_end) begin
      w_done_nxt = 1'b1;
      if (w_tohost) begin
        w_exit_nxt = bus.mem_wdata;
        if (bus.mem_wdata == XLEN'(1)) begin
          w_pass_nxt = 1'b1;
          w_fail_nxt = FAIL_NONE;
        end else begin
          w_pass_nxt = 1'b0;
          w_fail_nxt = FAIL_EXIT;
        end
      end else if (w_hang) begin
        w_pass_nxt = 1'b0;
        w_fail_nxt = FAIL_HANG;
      end else begin
        w_pass_nxt = 1'b0;
        w_fail_nxt = FAIL_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_core_rst  <= 1'b1;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_code <= FAIL_NONE;
      r_exit_code <= '0;
    end else begin
      r_core_rst  <= w_core_rst_nxt;
      r_running   <= w_running_nxt;
      r_done      <= w_done_nxt;
      r_pass      <= w_pass_nxt;
      r_fail_code <= w_fail_nxt;
      r_exit_code <= w_exit_nxt;
    end
  end

  assign bus.core_rst     = r_core_rst;
  assign bus.running      = r_running;
  assign bus.done         = r_done;
  assign bus.pass         = r_pass;
  assign bus.fail_code    = r_fail_code;
  assign bus.exit_code    = r_exit_code;
  assign bus.cycle_count  = w_cycle_q;
  assign bus.retire_count = w_retire_q;

endmodule
`default_nettype wire

// File: tb/tb_sim_harness_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sim_harness_ctrl
// Purpose  : Self-checking bench for sim_harness_ctrl. Each run pushes its
//            expected end-of-test status into a queue; a monitor pops and
//            compares when done rises. Directed checks cover reset, HOLD
//            timing, freezing in DONE and asynchronous reset mid-run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sim_harness_ctrl;

  localparam int          RST_CYC = 4;
  localparam logic [31:0] TOHOST  = 32'h0000_1000;

  typedef struct {
    logic        pass;
    logic [1:0]  fc;
    logic [31:0] exit_code;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  exp_t q_exp[$];
  exp_t mon_e;
  logic prev_done;

  sim_harness_ctrl_if #(.XLEN(32), .CNT_W(32)) bus ();

  sim_harness_ctrl #(
    .XLEN        (32),
    .CNT_W       (32),
    .RST_CYCLES  (RST_CYC),
    .MAX_CYCLES  (16),
    .STALL_LIMIT (8),
    .TOHOST_ADDR (TOHOST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare end-of-test status when done rises.
  always @(negedge clk) begin
    if (bus.done === 1'b1 && prev_done !== 1'b1) begin
      if (q_exp.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got done=1 expected no pending run at %0t", $time);
      end else begin
        mon_e = q_exp.pop_front();
        chk("end_pass",      bus.pass,         mon_e.pass);
        chk("end_fail_code", bus.fail_code,    mon_e.fc);
        chk("end_exit_code", bus.exit_code,    mon_e.exit_code);
        chk("end_cycles",    bus.cycle_count,  mon_e.cyc);
        chk("end_retired",   bus.retire_count, mon_e.ret);
      end
    end
    prev_done = bus.done;
  end

  // Pulse start and check core_rst is held exactly RST_CYC cycles.
  task automatic start_run();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < RST_CYC; i++) begin
      chk("hold_core_rst", bus.core_rst, 1'b1);
      chk("hold_running",  bus.running,  1'b0);
      @(negedge clk);
    end
    chk("run_core_rst", bus.core_rst, 1'b0);
    chk("run_running",  bus.running,  1'b1);
    chk("run_done",     bus.done,     1'b0);
  endtask

  // Drive n RUN cycles: retire in cycles 1..ret_n, tohost store in cycle
  // store_at (0 = never); other even cycles carry a decoy store next door.
  task automatic drive(input int n, input int ret_n, input int store_at, input logic [31:0] wdata);
    for (int i = 1; i <= n; i++) begin
      bus.retire_valid = (i <= ret_n);
      if (i == store_at) begin
        bus.mem_we = 1'b1; bus.mem_addr = TOHOST; bus.mem_wdata = wdata;
      end else begin
        bus.mem_we = (i % 2 == 0); bus.mem_addr = TOHOST + 32'd4; bus.mem_wdata = 32'd1;
      end
      @(negedge clk);
    end
    bus.retire_valid = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
  endtask

  task automatic finish_run();
    @(negedge clk);
    chk("queue_drained", q_exp.size(), 0);
    chk("end_running",   bus.running,  1'b0);
    chk("end_core_rst",  bus.core_rst, 1'b1);
    chk("end_done",      bus.done,     1'b1);
  endtask

  task automatic push(input logic p, input logic [1:0] fc, input logic [31:0] ex,
                      input logic [31:0] cyc, input logic [31:0] ret);
    exp_t e;
    e.pass = p; e.fc = fc; e.exit_code = ex; e.cyc = cyc; e.ret = ret;
    q_exp.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_total = 0; prev_done = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0; bus.retire_valid = 1'b0; bus.mem_we = 1'b0;
    bus.mem_addr = '0; bus.mem_wdata = '0;

    @(negedge clk);
    chk("rst_core_rst",  bus.core_rst,     1'b1);
    chk("rst_running",   bus.running,      1'b0);
    chk("rst_done",      bus.done,         1'b0);
    chk("rst_pass",      bus.pass,         1'b0);
    chk("rst_fail_code", bus.fail_code,    2'b00);
    chk("rst_exit_code", bus.exit_code,    32'd0);
    chk("rst_cycles",    bus.cycle_count,  32'd0);
    chk("rst_retired",   bus.retire_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Tohost pass after 10 retiring cycles.
    push(1'b1, 2'b00, 32'd1, 32'd10, 32'd10);
    start_run();
    drive(10, 10, 10, 32'd1);
    finish_run();

    // Identical rerun straight from DONE.
    push(1'b1, 2'b00, 32'd1, 32'd10, 32'd10);
    start_run();
    drive(10, 10, 10, 32'd1);
    finish_run();

    // Nonzero exit value, then check everything stays frozen.
    push(1'b0, 2'b01, 32'd7, 32'd5, 32'd3);
    start_run();
    drive(5, 3, 5, 32'd7);
    finish_run();
    for (int i = 0; i < 20; i++) begin
      bus.retire_valid = 1'b1; bus.mem_we = 1'b1;
      bus.mem_addr = TOHOST; bus.mem_wdata = 32'd1;
      @(negedge clk);
    end
    bus.retire_valid = 1'b0; bus.mem_we = 1'b0;
    chk("frz_core_rst",  bus.core_rst,     1'b1);
    chk("frz_cycles",    bus.cycle_count,  32'd5);
    chk("frz_retired",   bus.retire_count, 32'd3);
    chk("frz_pass",      bus.pass,         1'b0);
    chk("frz_fail_code", bus.fail_code,    2'b01);
    chk("frz_exit_code", bus.exit_code,    32'd7);

    // Timeout at 16 RUN cycles.
    push(1'b0, 2'b10, 32'd0, 32'd16, 32'd16);
    start_run();
    drive(16, 16, 0, 32'd0);
    finish_run();

    // Hang: 3 retires, then 8 idle cycles -> ends in cycle 11.
    push(1'b0, 2'b11, 32'd0, 32'd11, 32'd3);
    start_run();
    drive(11, 3, 0, 32'd0);
    finish_run();

    // Tohost on the same cycle as the 8th idle cycle wins over hang.
    push(1'b1, 2'b00, 32'd1, 32'd10, 32'd2);
    start_run();
    drive(10, 2, 10, 32'd1);
    finish_run();

    // Asynchronous reset in the middle of a run.
    start_run();
    drive(5, 5, 0, 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_core_rst",  bus.core_rst,     1'b1);
    chk("arst_running",   bus.running,      1'b0);
    chk("arst_done",      bus.done,         1'b0);
    chk("arst_fail_code", bus.fail_code,    2'b00);
    chk("arst_cycles",    bus.cycle_count,  32'd0);
    chk("arst_retired",   bus.retire_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_idle_core_rst", bus.core_rst, 1'b1);
    chk("arst_queue_empty",   q_exp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
